// File: rtl/mux_advanced_7segment.sv
// mux_advanced_7segment: priority-selects alarm/time/set word, drives four registered 7-seg codes
// and a registered alarm-match indication.
module mux_advanced_7segment (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] alarmData,
  input  logic [15:0] timeData,
  input  logic [15:0] setData,
  input  logic        showAlarm,
  input  logic        showTime,
  input  logic        alarmOn,
  output logic [27:0] display7Segment,
  output logic        soundAlarm
);
  logic [15:0] sel_data;
  logic [27:0] display_d, display_q;
  logic        sound_d, sound_q;
  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    case (n)
      4'h0: seg_enc = 7'h7E;
      4'h1: seg_enc = 7'h30;
      4'h2: seg_enc = 7'h6D;
      4'h3: seg_enc = 7'h79;
      4'h4: seg_enc = 7'h33;
      4'h5: seg_enc = 7'h5B;
      4'h6: seg_enc = 7'h5F;
      4'h7: seg_enc = 7'h70;
      4'h8: seg_enc = 7'h7F;
      4'h9: seg_enc = 7'h7B;
      4'hA: seg_enc = 7'h77;
      4'hB: seg_enc = 7'h1F;
      4'hC: seg_enc = 7'h4E;
      4'hD: seg_enc = 7'h3D;
      4'hE: seg_enc = 7'h4F;
      default: seg_enc = 7'h47;
    endcase
  endfunction
  always_comb begin
    sel_data  = showAlarm ? alarmData : (showTime ? timeData : setData);
    display_d = {seg_enc(sel_data[15:12]), seg_enc(sel_data[11:8]),
                 seg_enc(sel_data[7:4]), seg_enc(sel_data[3:0])};
    sound_d   = alarmOn && (alarmData == timeData);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display_q <= '0;
      sound_q   <= 1'b0;
    end else begin
      display_q <= display_d;
      sound_q   <= sound_d;
    end
  end
  assign display7Segment = display_q;
  assign soundAlarm      = sound_q;
endmodule

// File: tb/tb_mux_advanced_7segment.sv
// tb_mux_advanced_7segment: directed and randomized checks against a table-driven reference model.
module tb_mux_advanced_7segment;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] alarmData = '0, timeData = '0, setData = '0;
  logic        showAlarm = 1'b0, showTime = 1'b0, alarmOn = 1'b0;
  logic [27:0] display7Segment;
  logic        soundAlarm;
  int errors = 0;
  int checks = 0;
  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  mux_advanced_7segment dut (
    .clk(clk), .reset(reset), .alarmData(alarmData), .timeData(timeData), .setData(setData),
    .showAlarm(showAlarm), .showTime(showTime), .alarmOn(alarmOn),
    .display7Segment(display7Segment), .soundAlarm(soundAlarm)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] model_disp(input logic [15:0] v);
    logic [27:0] r;
    for (int i = 0; i < 4; i++) r[i*7 +: 7] = seg_tab[v[i*4 +: 4]];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] t, input logic [15:0] s,
                       input logic sa, input logic st, input logic on);
    @(negedge clk);
    alarmData = a; timeData = t; setData = s;
    showAlarm = sa; showTime = st; alarmOn = on;
  endtask

  task automatic test_reset();
    alarmData = 16'h1234; timeData = 16'h1234; setData = 16'hBEEF;
    showAlarm = 1'b1; showTime = 1'b0; alarmOn = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (display7Segment !== 28'h0) begin
      errors++; $display("FAIL reset_disp got=%h exp=%h", display7Segment, 28'h0);
    end
    checks++;
    if (soundAlarm !== 1'b0) begin
      errors++; $display("FAIL reset_sound got=%b exp=0", soundAlarm);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_match_display();
    drive(16'h000B, 16'h000B, 16'h0000, 1'b0, 1'b1, 1'b1);
    step();
    checks++;
    if (display7Segment !== 28'hFDFBF1F) begin
      errors++; $display("FAIL match_disp got=%h exp=FDFBF1F", display7Segment);
    end
    checks++;
    if (soundAlarm !== 1'b1) begin
      errors++; $display("FAIL match_sound got=%b exp=1", soundAlarm);
    end
  endtask

  task automatic test_increment(input logic on);
    for (int t = 16'h0007; t <= 16'h000F; t++) begin
      drive(16'h000B, 16'(t), 16'h0000, 1'b0, 1'b1, on);
      step();
      checks++;
      if (soundAlarm !== (on && t == 16'h000B)) begin
        errors++;
        $display("FAIL incr_sound on=%b time=%h got=%b exp=%b", on, t, soundAlarm, on && t == 16'h000B);
      end
    end
  endtask

  task automatic test_set_and_priority();
    drive(16'h0999, 16'h0888, 16'h0013, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (display7Segment !== 28'hFDF9879) begin
      errors++; $display("FAIL set_disp got=%h exp=FDF9879", display7Segment);
    end
    drive(16'h0041, 16'h0777, 16'h0013, 1'b1, 1'b1, 1'b0);
    step();
    checks++;
    if (display7Segment !== 28'hFDF99B0) begin
      errors++; $display("FAIL prio_disp got=%h exp=FDF99B0", display7Segment);
    end
  endtask

  task automatic test_sweep();
    for (int n = 0; n < 16; n++) begin
      drive(16'h5550, 16'h6660, {12'h000, 4'(n)}, 1'b0, 1'b0, 1'b1);
      step();
      checks++;
      if (display7Segment[6:0] !== seg_tab[n] || display7Segment[27:7] !== {3{7'h7E}}) begin
        errors++; $display("FAIL sweep n=%0h got=%h exp_digit0=%h", n, display7Segment, seg_tab[n]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, t, s;
    logic sa, st, on;
    logic [27:0] exp_d;
    logic exp_s;
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom); s = 16'($urandom);
      t = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      if ($urandom_range(0, 7) == 0) t = a ^ (16'h1 << $urandom_range(0, 15));
      sa = 1'($urandom); st = 1'($urandom); on = 1'($urandom);
      exp_d = model_disp(sa ? a : (st ? t : s));
      exp_s = on && (a == t);
      drive(a, t, s, sa, st, on);
      step();
      checks++;
      if (display7Segment !== exp_d || soundAlarm !== exp_s) begin
        errors++;
        $display("FAIL rand i=%0d disp got=%h exp=%h sound got=%b exp=%b", i, display7Segment, exp_d, soundAlarm, exp_s);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(16'h2222, 16'h2222, 16'h0000, 1'b1, 1'b0, 1'b1);
    step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (display7Segment !== 28'h0 || soundAlarm !== 1'b0) begin
      errors++; $display("FAIL mid_reset disp=%h sound=%b exp=0/0", display7Segment, soundAlarm);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++;
    if (display7Segment !== model_disp(16'h2222) || soundAlarm !== 1'b1) begin
      errors++;
      $display("FAIL post_reset disp got=%h exp=%h sound got=%b exp=1", display7Segment, model_disp(16'h2222), soundAlarm);
    end
  endtask

  initial begin
    test_reset();
    test_match_display();
    test_increment(1'b1);
    test_increment(1'b0);
    test_set_and_priority();
    test_sweep();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
